lsu_bus_ctrl: RTL

- Load/store unit that consumes the controller's memory-control outputs (MemRead, MemWrite, Mem_mode, Mem_read_us) plus address and store data.
- Executes the access on a word-wide, handshaked data-memory bus.
- Sits between the execute stage and data memory; stalls the core while an access is outstanding.
- Generates byte strobes and store-data lane steering; returns sign- or zero-extended load data.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_bus_ctrl_lane_align.sv | 52 +++++
 rtl/lsu_bus_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store bus controller: access sizes,
// response error codes and the controller state enum.
package lsu_pkg;

    // Mem_mode access-size encodings; every other value is illegal.
    localparam logic [2:0] MODE_B = 3'b000;
    localparam logic [2:0] MODE_H = 3'b001;
    localparam logic [2:0] MODE_W = 3'b010;

    // Error codes that accompany resp_valid.
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Controller states: waiting for a request, driving the bus, responding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Byte-lane logic for one access. It produces the write strobes, replicates
// store data onto every lane the size allows, extracts and extends the load
// lane from the bus word, and flags size/alignment violations.
module lsu_bus_ctrl_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_mode,
    input  logic        i_read_us,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [31:0] w_shifted;

    // The addressed lane is moved down to bit 0 before extension.
    assign w_shifted = i_bus_rdata >> {i_addr_lo, 3'b000};

    // Per-size strobes, store replication, load extension and legality.
    always_comb begin
        o_wstrb    = 4'b0000;
        o_wdata    = i_wdata;
        o_rdata    = '0;
        o_misalign = 1'b0;
        case (i_mode)
            MODE_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_read_us & w_shifted[7]}}, w_shifted[7:0]};
            end
            MODE_H: begin
                o_misalign = i_addr_lo[0];
                o_wstrb    = 4'b0011 << i_addr_lo;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{~i_read_us & w_shifted[15]}}, w_shifted[15:0]};
            end
            MODE_W: begin
                o_misalign = (i_addr_lo != 2'b00);
                o_wstrb    = 4'b1111;
                o_rdata    = i_bus_rdata;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller. It accepts one memory access from the
// execute stage, runs it on a word-wide handshaked data bus (or rejects it
// for size/alignment), and returns a one-cycle response with extended load
// data and an error code. A cycle budget aborts accesses the bus never acks.
//
// Handshake: a request is accepted on a cycle where req_ready=1 and
// req_valid=1 with exactly one of MemRead/MemWrite set; the core holds the
// request stable until resp_valid. On the bus side bus_req and all bus_*
// qualifiers stay constant until the cycle bus_ack=1, which also carries
// bus_rdata; bus_ack in any other state is ignored.
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Mem_mode,
    input  logic              Mem_read_us,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic [1:0]        err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output lsu_state_e        dbg_state
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_mode;
    logic              r_us;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_err;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_wstrb;
    logic [31:0]       r_bus_wdata;

    logic              w_accept;
    logic              w_timeout;
    logic [1:0]        w_sel_addr_lo;
    logic [2:0]        w_sel_mode;
    logic              w_sel_us;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata_ext;
    logic              w_misalign;

    assign w_accept  = (r_state == S_IDLE) & req_valid & (MemRead ^ MemWrite);
    assign w_timeout = (r_cnt == CNT_LAST);

    // While idle the lane logic judges the incoming request; once accepted it
    // works from the latched copy so the load extension matches the request.
    assign w_sel_addr_lo = (r_state == S_IDLE) ? addr[1:0]   : r_addr_lo;
    assign w_sel_mode    = (r_state == S_IDLE) ? Mem_mode    : r_mode;
    assign w_sel_us      = (r_state == S_IDLE) ? Mem_read_us : r_us;

    lsu_bus_ctrl_lane_align u_align (
        .i_addr_lo   (w_sel_addr_lo),
        .i_mode      (w_sel_mode),
        .i_read_us   (w_sel_us),
        .i_wdata     (wdata),
        .i_bus_rdata (bus_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_rdata     (w_rdata_ext),
        .o_misalign  (w_misalign)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        bus_req     = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_misalign ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                bus_req = 1'b1;
                // An ack on the last budgeted cycle still completes normally.
                if (bus_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Cycle budget for the bus wait: cleared at acceptance, counts unacked cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if ((r_state == S_BUS) && !bus_ack && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Request latch, bus qualifiers and the response data/error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_lo   <= '0;
            r_mode      <= '0;
            r_us        <= 1'b0;
            r_rdata     <= '0;
            r_err       <= ERR_OK;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= '0;
            r_bus_wdata <= '0;
        end else if (w_accept) begin
            r_addr_lo <= addr[1:0];
            r_mode    <= Mem_mode;
            r_us      <= Mem_read_us;
            if (w_misalign) begin
                r_rdata <= '0;
                r_err   <= ERR_ALIGN;
            end else begin
                r_bus_we    <= MemWrite;
                r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_bus_wstrb <= w_wstrb;
                r_bus_wdata <= w_wdata;
            end
        end else if (r_state == S_BUS) begin
            if (bus_ack) begin
                r_rdata <= r_bus_we ? 32'd0 : w_rdata_ext;
                r_err   <= ERR_OK;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= ERR_TIMEOUT;
            end
        end
    end

    assign stall     = req_valid & (MemRead | MemWrite) & ~resp_valid;
    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_wdata = r_bus_wdata;
    assign dbg_state = r_state;

endmodule
